product_bcd_converter: RTL

Sequential binary-to-BCD converter that sits directly downstream of the pipelined 4x4 multiplier. It takes the 8-bit product `P` and produces three packed BCD digits (hundreds/tens/units) for the calculator display path. It uses the iterative shift-and-add-3 (double-dabble) algorithm, one bit per cycle, with a valid/ready input handshake and a one-cycle done pulse. It also honours the same global `enable` stall as the multiplier pipeline.

---
 rtl/product_bcd_converter.sv | 114 +++++++++++
 1 files changed

// File: rtl/product_bcd_converter.sv
// ---------------------------------------------------------------------------
// product_bcd_converter
//
// Converts the unsigned binary product of the 4x4 multiplier into packed BCD
// digits for the calculator display. It uses iterative shift-and-add-3
// (double dabble) and handles one binary bit per enabled clock edge.
//
// Ports:
//   clock     - single clock; all state updates on the rising edge
//   rst       - asynchronous, active-high reset; clears all state
//   enable    - global stall; low freezes every register
//   in_valid  - P_in holds a product to convert
//   P_in      - unsigned binary product, WIDTH bits
//   in_ready  - converter is idle and accepts on this cycle
//   busy      - conversion in progress (SHIFT or DONE)
//   bcd_out   - packed BCD, units in [3:0]; registered, whole-result update
//   out_valid - one-cycle pulse; bcd_out was updated at the preceding edge
// ---------------------------------------------------------------------------
module product_bcd_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      P_in,
    output logic                  in_ready,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  out_valid
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + WIDTH;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_reg;
    logic [WORK_W-1:0]   work_reg;
    logic [CNT_W-1:0]    cnt_reg;

    // Add-3 adjusted copy of the working register, then shifted copy.
    logic [WORK_W-1:0]   adjusted;
    logic [WORK_W-1:0]   shifted;

    // Each BCD digit is corrected independently: a 4-bit add with no carry
    // into the next digit. A digit >= 5 becomes >= 8 so that the following
    // shift carries it correctly into the next decade.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit_adjust
            logic [3:0] digit;
            assign digit = work_reg[WIDTH + 4*gi +: 4];
            assign adjusted[WIDTH + 4*gi +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
        end
    endgenerate

    assign adjusted[WIDTH-1:0] = work_reg[WIDTH-1:0];
    assign shifted             = adjusted << 1;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            work_reg  <= '0;
            cnt_reg   <= '0;
            bcd_out   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else if (enable) begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        work_reg  <= {{BCD_W{1'b0}}, P_in};
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    work_reg <= shifted;
                    cnt_reg  <= cnt_reg + 1'b1;
                    // Final shift: publish the complete BCD field in one go.
                    if (cnt_reg == LAST_CNT) begin
                        bcd_out   <= shifted[WORK_W-1 -: BCD_W];
                        out_valid <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
